// File: rtl/uart_rom_loader.sv
// UART bootloader: receives a framed program, writes it into the instruction ROM and
// holds the CPU in reset until the frame checksum passes.
module uart_rom_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned TIMEOUT_CLKS = 1000000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  rx_i,
  output logic                  rom_we_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic [15:0]           rom_data_o,
  output logic                  cpu_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned GapW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GapW-1:0] GapLimit = GapW'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [3:0] {
    LdIdle, LdLenHi, LdLenLo, LdDataHi, LdDataLo, LdCheck, LdDone, LdError
  } ld_state_e;

  // ---------------- receiver ----------------
  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid, frame_err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        cnt_d = '0;
        bit_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d      = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;  // high at mid-start: glitch
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          rx_state_d = RxIdle;
          byte_valid = rx_sync_q;
          frame_err  = !rx_sync_q;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------- loader ----------------
  ld_state_e             ld_q, ld_d;
  logic [15:0]           len_q, len_d, data_q, data_d;
  logic [7:0]            hi_q, hi_d, chk_q, chk_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic                  we_q, we_d, hold_q, hold_d, busy_q, busy_d, done_q, done_d;
  logic                  err_q, err_d, pass, fail, in_frame, last_word;
  logic [15:0]           len_new;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ld_q   <= LdIdle;
      len_q  <= '0;
      data_q <= '0;
      hi_q   <= '0;
      chk_q  <= '0;
      addr_q <= '0;
      gap_q  <= '0;
      we_q   <= 1'b0;
      hold_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ld_q   <= ld_d;
      len_q  <= len_d;
      data_q <= data_d;
      hi_q   <= hi_d;
      chk_q  <= chk_d;
      addr_q <= addr_d;
      gap_q  <= gap_d;
      we_q   <= we_d;
      hold_q <= hold_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign len_new   = {len_q[15:8], shift_q};
  assign last_word = (32'(addr_q) + 32'd1) == 32'(len_q);
  assign in_frame  = ld_q inside {LdLenHi, LdLenLo, LdDataHi, LdDataLo, LdCheck};

  always_comb begin
    ld_d   = ld_q;
    len_d  = len_q;
    data_d = data_q;
    hi_d   = hi_q;
    chk_d  = chk_q;
    addr_d = we_q ? addr_q + 1'b1 : addr_q;
    gap_d  = '0;
    we_d   = 1'b0;
    hold_d = hold_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
    pass   = 1'b0;
    fail   = 1'b0;
    unique case (ld_q)
      LdIdle: begin
        if (byte_valid && shift_q == 8'hA5) begin
          ld_d   = LdLenHi;
          hold_d = 1'b1;
          busy_d = 1'b1;
          done_d = 1'b0;
          err_d  = 1'b0;
          addr_d = '0;
          chk_d  = '0;
        end
      end
      LdLenHi: if (byte_valid) begin
        len_d[15:8] = shift_q;
        chk_d       = chk_q ^ shift_q;
        ld_d        = LdLenLo;
      end
      LdLenLo: if (byte_valid) begin
        len_d[7:0] = shift_q;
        chk_d      = chk_q ^ shift_q;
        if (32'(len_new) > (32'd1 << ADDR_WIDTH)) fail = 1'b1;
        else if (len_new == 16'd0)                ld_d = LdCheck;
        else                                      ld_d = LdDataHi;
      end
      LdDataHi: if (byte_valid) begin
        hi_d  = shift_q;
        chk_d = chk_q ^ shift_q;
        ld_d  = LdDataLo;
      end
      LdDataLo: if (byte_valid) begin
        data_d = {hi_q, shift_q};
        we_d   = 1'b1;
        chk_d  = chk_q ^ shift_q;
        ld_d   = last_word ? LdCheck : LdDataHi;
      end
      LdCheck: if (byte_valid) begin
        if (shift_q == chk_q) pass = 1'b1;
        else                  fail = 1'b1;
      end
      LdDone, LdError: ld_d = LdIdle;
      default: ld_d = LdIdle;
    endcase
    if (in_frame) begin
      gap_d = byte_valid ? '0 : gap_q + 1'b1;
      if (frame_err || (!byte_valid && gap_q == GapLimit)) fail = 1'b1;
    end
    if (pass) begin
      ld_d   = LdDone;
      done_d = 1'b1;
      hold_d = 1'b0;
      busy_d = 1'b0;
    end
    if (fail) begin
      ld_d   = LdError;
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  assign rom_we_o   = we_q;
  assign rom_addr_o = addr_q;
  assign rom_data_o = data_q;
  assign cpu_hold_o = hold_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader: frames sent bit-serially, ROM writes captured and
// compared against hand-computed words and status flags.
module tb_uart_rom_loader;
  localparam int unsigned Cpb = 4;
  localparam int unsigned Aw  = 15;

  logic          clk = 1'b0;
  logic          reset, rx;
  logic          rom_we, cpu_hold, busy, done, err;
  logic [Aw-1:0] rom_addr;
  logic [15:0]   rom_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  tx_q[$];
  logic        prev_we = 1'b0;
  int          consec_we = 0;

  uart_rom_loader #(
    .CLKS_PER_BIT(Cpb),
    .ADDR_WIDTH  (Aw),
    .TIMEOUT_CLKS(200)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .rx_i      (rx),
    .rom_we_o  (rom_we),
    .rom_addr_o(rom_addr),
    .rom_data_o(rom_data),
    .cpu_hold_o(cpu_hold),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rom_we) begin
      wr_addr.push_back(32'(rom_addr));
      wr_data.push_back(32'(rom_data));
      if (prev_we) consec_we++;
    end
    prev_we = rom_we;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] wr_at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(Cpb);
    end
    rx = stop_bit;
    idle(Cpb);
    rx = 1'b1;
    idle(2);
  endtask

  task automatic send_queue();
    foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    idle(6);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    rx    = 1'b1;
    reset = 1'b1;
    idle(3);
    check("rst_we", 32'(rom_we), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_data", 32'(rom_data), 0);
    check("rst_hold", 32'(cpu_hold), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b0;
    idle(4);

    // 1: two words, checksum 00^02^12^34^AB^CD = 42
    clear_log();
    send_byte(8'hA5, 1'b1);
    idle(4);
    check("t1_hold_on", 32'(cpu_hold), 1);
    check("t1_busy_on", 32'(busy), 1);
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    send_queue();
    check("t1_nwr", 32'(wr_data.size()), 2);
    check("t1_a0", wr_at(wr_addr, 0), 0);
    check("t1_d0", wr_at(wr_data, 0), 32'h1234);
    check("t1_a1", wr_at(wr_addr, 1), 1);
    check("t1_d1", wr_at(wr_data, 1), 32'hABCD);
    check("t1_done", 32'(done), 1);
    check("t1_err", 32'(err), 0);
    check("t1_hold", 32'(cpu_hold), 0);
    check("t1_busy", 32'(busy), 0);

    // 2: same frame, bad checksum
    clear_log();
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h46};
    send_queue();
    check("t2_nwr", 32'(wr_data.size()), 2);
    check("t2_d1", wr_at(wr_data, 1), 32'hABCD);
    check("t2_err", 32'(err), 1);
    check("t2_done", 32'(done), 0);
    check("t2_hold", 32'(cpu_hold), 1);
    check("t2_busy", 32'(busy), 0);

    // 3: empty program
    clear_log();
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_queue();
    check("t3_nwr", 32'(wr_data.size()), 0);
    check("t3_done", 32'(done), 1);
    check("t3_hold", 32'(cpu_hold), 0);

    // 4: line glitch and stray byte before the frame
    clear_log();
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(60);
    check("t4_glitch_busy", 32'(busy), 0);
    tx_q = '{8'h55, 8'hA5, 8'h00, 8'h01, 8'h00, 8'h07, 8'h06};
    send_queue();
    check("t4_nwr", 32'(wr_data.size()), 1);
    check("t4_d0", wr_at(wr_data, 0), 32'h0007);
    check("t4_done", 32'(done), 1);

    // 5a: inter-byte timeout after one word
    clear_log();
    tx_q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    send_queue();
    check("t5_busy_mid", 32'(busy), 1);
    idle(250);
    check("t5_nwr", 32'(wr_data.size()), 1);
    check("t5_d0", wr_at(wr_data, 0), 32'h1122);
    check("t5_err", 32'(err), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_hold", 32'(cpu_hold), 1);

    // 5b: framing error mid-frame
    tx_q = '{8'hA5, 8'h00, 8'h01};
    send_queue();
    check("t5b_err_clr", 32'(err), 0);
    send_byte(8'h12, 1'b0);
    idle(6);
    check("t5b_err", 32'(err), 1);
    check("t5b_busy", 32'(busy), 0);

    // 5c: length one past the address space
    tx_q = '{8'hA5, 8'h80, 8'h01};
    send_queue();
    check("t5c_err", 32'(err), 1);
    check("t5c_busy", 32'(busy), 0);

    // 6: reset after a DATA_HI byte, then a clean frame (00^01^BE^EF = 50)
    clear_log();
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'hAA};
    send_queue();
    reset = 1'b1;
    @(negedge clk);
    check("t6_hold", 32'(cpu_hold), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_err", 32'(err), 0);
    check("t6_addr", 32'(rom_addr), 0);
    reset = 1'b0;
    idle(4);
    send_byte(8'hBB, 1'b1);
    idle(6);
    check("t6_nwr", 32'(wr_data.size()), 0);
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h50};
    send_queue();
    check("t6_nwr2", 32'(wr_data.size()), 1);
    check("t6_a0", wr_at(wr_addr, 0), 0);
    check("t6_d0", wr_at(wr_data, 0), 32'hBEEF);
    check("t6_done", 32'(done), 1);
    check("t6_hold2", 32'(cpu_hold), 0);

    check("we_spacing", 32'(consec_we), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
